// File: rtl/keypad_row_debounce.sv
// keypad_row_debounce
//
// Synchronizes and debounces the raw keypad row pins before they reach the
// column-scan FSM, and produces one-cycle press/release strobes.
//
// Parameters:
//   WIDTH  - number of row lines
//   THRESH - consecutive disagreeing ticks needed to accept a new level (1..255)
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   reset       - synchronous, active-high reset
//   tick_i      - one-cycle sample enable (scanner update timer pulse)
//   flush_i     - synchronous clear of debounce state (scanner column change)
//   rows_raw_i  - asynchronous row pin levels, 1 = pressed
//   rows_db_o   - debounced row levels
//   press_o     - one-cycle strobe when rows_db_o goes all-zero -> nonzero
//   release_o   - one-cycle strobe when rows_db_o goes nonzero -> all-zero
//   busy_o      - high while any row has a pending (nonzero) disagreement count

module keypad_row_debounce #(
    parameter int WIDTH  = 4,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] rows_raw_i,
    output logic [WIDTH-1:0] rows_db_o,
    output logic             press_o,
    output logic             release_o,
    output logic             busy_o
);

    // THRESH of 1 or 2 still needs a one-bit counter
    localparam int CW = (THRESH > 2) ? $clog2(THRESH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(THRESH - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] rows_db_q;
    logic [WIDTH-1:0] rows_db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Per-row debounce: a row's counter tracks the current run of ticks on
    // which the synchronized level disagrees with the debounced level. Any
    // agreeing tick breaks the run; the THRESH-th disagreeing tick accepts
    // the new level. Flush overrides the tick entirely.
    always_comb begin
        rows_db_d = rows_db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (flush_i) begin
            rows_db_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (tick_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == rows_db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    rows_db_d[i] = s2_q[i];
                    cnt_d[i]     = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Strobes look at the whole row vector, so moving between two nonzero
    // patterns produces neither. A flush clears rows_db but must never
    // report a release.
    always_comb begin
        press_d   = !flush_i && (rows_db_q == '0) && (rows_db_d != '0);
        release_d = !flush_i && (rows_db_q != '0) && (rows_db_d == '0);
    end

    // A change is pending whenever any row has a nonzero run count.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q[i] != '0) begin
                busy_o = 1'b1;
            end
        end
    end

    // The two-flop synchronizer runs every clock; the debounce state only
    // moves on tick or flush, which is already folded into the _d values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            rows_db_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= rows_raw_i;
            s2_q      <= s1_q;
            rows_db_q <= rows_db_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rows_db_o = rows_db_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: tb/tb_keypad_row_debounce.sv
// tb_keypad_row_debounce
//
// Drives two instances of keypad_row_debounce (THRESH=4 and THRESH=1) from
// the same stimulus and compares both against a behavioural model that
// tracks, per row, how many consecutive tick samples have disagreed with
// the accepted level.

module tb_keypad_row_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       flush;
    logic [3:0] rows_raw;

    logic [3:0] db4;
    logic       p4;
    logic       r4;
    logic       b4;
    logic [3:0] db1;
    logic       p1;
    logic       r1;
    logic       b1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: raw pin history, accepted level, run length
    logic [3:0] s1m;
    logic [3:0] s2m;
    logic [3:0] dbm [2];
    logic       pm  [2];
    logic       rm  [2];
    int         run [2][4];
    int         thr [2];

    keypad_row_debounce #(.WIDTH(4), .THRESH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick),
        .flush_i    (flush),
        .rows_raw_i (rows_raw),
        .rows_db_o  (db4),
        .press_o    (p4),
        .release_o  (r4),
        .busy_o     (b4)
    );

    keypad_row_debounce #(.WIDTH(4), .THRESH(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick),
        .flush_i    (flush),
        .rows_raw_i (rows_raw),
        .rows_db_o  (db1),
        .press_o    (p1),
        .release_o  (r1),
        .busy_o     (b1)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs being applied.
    task automatic model_update();
        logic [3:0] nd;
        if (reset) begin
            s1m = '0;
            s2m = '0;
            for (int k = 0; k < 2; k++) begin
                dbm[k] = '0;
                pm[k]  = 1'b0;
                rm[k]  = 1'b0;
                for (int i = 0; i < 4; i++) run[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    dbm[k] = '0;
                    pm[k]  = 1'b0;
                    rm[k]  = 1'b0;
                    for (int i = 0; i < 4; i++) run[k][i] = 0;
                end else begin
                    nd = dbm[k];
                    if (tick) begin
                        for (int i = 0; i < 4; i++) begin
                            if (s2m[i] == dbm[k][i]) begin
                                run[k][i] = 0;
                            end else if (run[k][i] + 1 == thr[k]) begin
                                nd[i] = s2m[i];
                                run[k][i] = 0;
                            end else begin
                                run[k][i] = run[k][i] + 1;
                            end
                        end
                    end
                    pm[k]  = (dbm[k] == 4'b0) && (nd != 4'b0);
                    rm[k]  = (dbm[k] != 4'b0) && (nd == 4'b0);
                    dbm[k] = nd;
                end
            end
            s2m = s1m;
            s1m = rows_raw;
        end
    endtask

    function automatic logic model_busy(int k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 4; i++) if (run[k][i] != 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {dbm[0], pm[0], rm[0], model_busy(0), dbm[1], pm[1], rm[1], model_busy(1)};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {db4, p4, r4, b4, db1, p1, r1, b1};
    endfunction

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Return both instances to a cleared, idle state with zero raw input.
    task automatic settle();
        rows_raw = 4'b0;
        tick     = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rows_raw = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            tick = (c % 4 == 3);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reset_model cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if ({db4, p4, r4, b4} !== 7'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 0", c, {db4, p4, r4, b4});
            end
        end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_clean_press();
        int presses;
        presses  = 0;
        rows_raw = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            tick = (c % 4 == 3);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL clean_press cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (p4) begin
                presses++;
                checks++;
                if (db4 !== 4'b0100) begin
                    errors++;
                    $display("[TB] FAIL clean_press_db_at_strobe: got %b expected 0100", db4);
                end
            end
        end
        checks++;
        if (presses !== 1 || db4 !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL clean_press_count: got %0d presses db %b expected 1 press db 0100", presses, db4);
        end
        settle();
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        for (int c = 0; c < 44; c++) begin
            rows_raw = (c / 4 == 2) ? 4'b0000 : 4'b0100;
            tick     = (c % 4 == 3);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL bounce cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (p4) presses++;
            if (c == 23) begin
                checks++;
                if (db4 !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL bounce_hold: got %b expected 0000", db4);
                end
            end
        end
        checks++;
        if (presses !== 1 || db4 !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL bounce_count: got %0d presses db %b expected 1 press db 0100", presses, db4);
        end
        settle();
    endtask

    task automatic test_release();
        int rels;
        int strobes;
        logic [3:0] pat [4];
        rels    = 0;
        strobes = 0;
        pat[0] = 4'b0010;
        pat[1] = 4'b0000;
        pat[2] = 4'b0010;
        pat[3] = 4'b0011;
        for (int ph = 0; ph < 4; ph++) begin
            rows_raw = pat[ph];
            for (int c = 0; c < 24; c++) begin
                tick = (c % 4 == 3);
                step();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL release phase %0d cycle %0d: got %b expected %b", ph, c, obs_vec(), exp_vec());
                end
                if (ph == 1 && r4) rels++;
                if (ph == 3 && (p4 || r4)) strobes++;
            end
        end
        checks++;
        if (rels !== 1) begin
            errors++;
            $display("[TB] FAIL release_count: got %0d expected 1", rels);
        end
        checks++;
        if (strobes !== 0 || db4 !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL nonzero_change: got %0d strobes db %b expected 0 strobes db 0011", strobes, db4);
        end
        settle();
    endtask

    task automatic test_flush_priority();
        int presses;
        presses  = 0;
        rows_raw = 4'b1000;
        for (int c = 0; c < 24; c++) begin
            tick = (c % 4 == 3);
            step();
        end
        checks++;
        if (db4 !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL flush_setup: got %b expected 1000", db4);
        end
        flush = 1'b1;
        tick  = 1'b1;
        step();
        flush = 1'b0;
        tick  = 1'b0;
        checks++;
        if ({db4, r4, b4, db1, r1} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL flush_clear: got %b expected 0", {db4, r4, b4, db1, r1});
        end
        for (int c = 0; c < 24; c++) begin
            tick = (c % 4 == 3);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL flush_reaccept cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
            if (r4) begin
                checks++;
                errors++;
                $display("[TB] FAIL flush_no_release: got 1 expected 0");
            end
            if (p4) presses++;
        end
        checks++;
        if (presses !== 1 || db4 !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL flush_press: got %0d presses db %b expected 1 press db 1000", presses, db4);
        end
        settle();
    endtask

    task automatic test_thresh1_gaps();
        rows_raw = 4'b0001;
        tick     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec() || db1 !== 4'b0) begin
                errors++;
                $display("[TB] FAIL thresh1_idle cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if (db1 !== 4'b0001 || p1 !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL thresh1_accept: got %b expected %b", obs_vec(), exp_vec());
        end
        step();
        checks++;
        if (p1 !== 1'b0 || db1 !== 4'b0001 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL thresh1_strobe_width: got %b expected %b", obs_vec(), exp_vec());
        end
        settle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 59) == 0);
            tick  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) rows_raw = 4'($urandom);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        tick  = 1'b0;
    endtask

    // Directed scenarios first, then a long randomized run with dense ticks.
    initial begin
        thr[0]   = 4;
        thr[1]   = 1;
        reset    = 1'b1;
        tick     = 1'b0;
        flush    = 1'b0;
        rows_raw = 4'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_flush_priority();
        test_thresh1_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
